// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared types for the keypad scanner.
//   res_kind_e / res_t : result of one whole-keypad frame (none, single key
//                        with its 4-bit code, or several keys at once)
//   ks_state_e         : press-tracking FSM states
//   res_merge()        : folds one column's row hits into a running result
// ---------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } res_kind_e;

    // The code field is kept at zero unless kind is RES_SINGLE, so two
    // results can be compared for equality as plain vectors.
    typedef struct packed {
        res_kind_e  kind;
        logic [3:0] code;
    } res_t;

    localparam res_t RES_CLEAR = '{kind: RES_NONE, code: 4'd0};

    typedef enum logic {
        KS_IDLE    = 1'b0,
        KS_PRESSED = 1'b1
    } ks_state_e;

    // Add the pressed rows of column 'col' to the result gathered so far.
    // Code is row*4 + col, i.e. {row, col}.
    function automatic res_t res_merge(input res_t       acc,
                                       input logic [3:0] rows,
                                       input logic [1:0] col);
        res_t       res;
        int         hits;
        logic [1:0] row;
        res  = acc;
        hits = 0;
        row  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (rows[i]) begin
                hits = hits + 1;
                row  = 2'(i);
            end
        end
        if (hits > 1 || (hits == 1 && acc.kind != RES_NONE)) begin
            res = '{kind: RES_MULTI, code: 4'd0};
        end else if (hits == 1) begin
            res = '{kind: RES_SINGLE, code: {row, col}};
        end
        return res;
    endfunction

endpackage

// File: rtl/key_scan_if.sv
// ---------------------------------------------------------------------------
// key_scan_if
// Keypad-side and result-side signals of the scanner.
//   row_n     : keypad rows, active-low (keypad -> scanner)
//   col_n     : column drive, active-low, one bit low (scanner -> keypad)
//   key_valid : one-cycle pulse per accepted press
//   key_code  : code of the last accepted key
//   key_down  : high while an accepted key is held
// master = the scanner, slave = keypad plus result consumer.
// ---------------------------------------------------------------------------
interface key_scan_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_down;

    modport master (input  row_n,
                    output col_n, key_valid, key_code, key_down);
    modport slave  (output row_n,
                    input  col_n, key_valid, key_code, key_down);
endinterface

// File: rtl/key_sync.sv
// ---------------------------------------------------------------------------
// key_sync
// Two-flop synchronizer for slow asynchronous level inputs (keypad rows,
// switches). Both flops clear to 0 on reset.
//   clk   : system clock
//   reset : synchronous, active-high
//   i_d   : asynchronous input bus
//   o_q   : synchronized output bus (2-cycle latency)
// ---------------------------------------------------------------------------
module key_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: non-blocking assignments so both flops sample the pre-edge
    // values; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_scan.sv
// ---------------------------------------------------------------------------
// key_scan
// 4x4 active-low matrix keypad scanner with whole-frame debouncing.
//   clk   : system clock
//   reset : synchronous, active-high
//   kp    : key_scan_if.master (row_n in; col_n, key_valid, key_code,
//           key_down out)
// Parameters:
//   SCAN_DIV : cycles each column is driven (>= 4)
//   DEBOUNCE : identical consecutive frames needed to accept a state (>= 1)
// ---------------------------------------------------------------------------
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic          clk,
    input  logic          reset,
    key_scan_if.master    kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int STB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);

    // ---------------- row synchronizer (1 = pressed) ----------------
    logic [3:0] w_row_raw;
    logic [3:0] w_row_s;

    assign w_row_raw = ~kp.row_n;

    key_sync #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_row_raw),
        .o_q   (w_row_s)
    );

    // ---------------- divider and column drive ----------------
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_col_idx;
    logic             w_sample;
    logic             w_frame_end;

    // Sampling on the last divider count gives the row lines at least two
    // cycles to settle through the synchronizer after the column switch.
    assign w_sample    = (r_div_cnt == DIV_LAST);
    assign w_frame_end = w_sample && (r_col_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_col_idx <= 2'd0;
        end else if (w_sample) begin
            r_div_cnt <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign kp.col_n = ~(4'b0001 << r_col_idx);

    // ---------------- frame accumulator ----------------
    res_t r_acc;
    res_t w_frame;

    // Column 0 starts a fresh frame; later columns extend the running one.
    // At frame end w_frame is the complete frame result.
    assign w_frame = res_merge((r_col_idx == 2'd0) ? RES_CLEAR : r_acc,
                               w_row_s, r_col_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= RES_CLEAR;
        end else if (w_sample) begin
            r_acc <= w_frame;
        end
    end

    // ---------------- debounce ----------------
    res_t             r_prev;
    logic [STB_W-1:0] r_stable_cnt;
    logic [STB_W-1:0] w_stable_next;
    logic             w_same;
    logic             w_accept;

    assign w_same = (w_frame == r_prev);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_stable_next = STB_ONE;
        if (w_same) begin
            w_stable_next = (r_stable_cnt == STB_MAX) ? r_stable_cnt
                                                      : r_stable_cnt + STB_ONE;
        end
    end

    // Accept only on the frame that brings the count up to DEBOUNCE, not on
    // the frames where it stays saturated.
    assign w_accept = w_frame_end && (w_stable_next == STB_MAX) &&
                      (!w_same || r_stable_cnt != STB_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev       <= RES_CLEAR;
            r_stable_cnt <= '0;
        end else if (w_frame_end) begin
            r_prev       <= w_frame;
            r_stable_cnt <= w_stable_next;
        end
    end

    // ---------------- press FSM ----------------
    ks_state_e r_state;
    ks_state_e w_state_next;
    logic      w_pulse;
    logic      r_key_valid;
    logic [3:0] r_key_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= KS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            KS_IDLE:
                if (w_accept && w_frame.kind == RES_SINGLE) begin
                    w_state_next = KS_PRESSED;
                end
            KS_PRESSED:
                // Any other key or a multi-press keeps us here until a full
                // release is accepted.
                if (w_accept && w_frame.kind == RES_NONE) begin
                    w_state_next = KS_IDLE;
                end
            default:
                w_state_next = KS_IDLE;
        endcase
    end

    always_comb begin
        w_pulse = 1'b0;
        if (r_state == KS_IDLE && w_accept && w_frame.kind == RES_SINGLE) begin
            w_pulse = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_key_valid <= w_pulse;
            if (w_pulse) begin
                r_key_code <= w_frame.code;
            end
        end
    end

    assign kp.key_valid = r_key_valid;
    assign kp.key_code  = r_key_code;
    assign kp.key_down  = (r_state == KS_PRESSED);

endmodule

// File: tb/tb_key_scan.sv
// ---------------------------------------------------------------------------
// tb_key_scan
// Bench for key_scan with SCAN_DIV = 4, DEBOUNCE = 2 (16-cycle frame).
// A keypad model pulls row r low when key (r, c) is held and column c is
// driven low. The reference model works per frame: it keeps a history of the
// held-key mask, reads each column's keys as they stood two cycles before
// that column's sample, classifies the frame by counting pressed keys, and
// applies the debounce and press/release rules to predict the outputs.
// ---------------------------------------------------------------------------
module tb_key_scan;

    localparam int SD  = 4;
    localparam int DEB = 2;

    logic clk;
    logic reset;
    logic [15:0] keys;    // bit r*4+c = key (row r, col c) held

    key_scan_if bus ();

    key_scan #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // keypad matrix
    logic [3:0] row_n_w;
    always_comb begin
        row_n_w = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && bus.col_n[c] == 1'b0) row_n_w[r] = 1'b0;
            end
        end
    end
    assign bus.row_n = row_n_w;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          m_n;          // edges since reset released
    logic [15:0] m_log [32];   // held-key mask before each edge
    int          m_acc_hits, m_acc_code;
    int          m_prev_kind, m_prev_code;   // kind: 0 none, 1 single, 2 multi
    int          m_stable;
    bit          m_pressed;
    bit          exp_valid;
    int          exp_code;
    int          m_pulses;

    task automatic model_edge();
        logic [15:0] m;
        int c, hits, code, kind, rcode;
        bit accept;
        exp_valid = 1'b0;
        if (reset) begin
            m_n = 0; m_acc_hits = 0; m_acc_code = 0;
            m_prev_kind = 0; m_prev_code = 0; m_stable = 0;
            m_pressed = 1'b0; exp_code = 0;
        end else begin
            m_n++;
            m_log[m_n % 32] = keys;
            if (m_n % SD == 0) begin
                c = ((m_n - 1) / SD) % 4;
                m = (m_n >= 3) ? m_log[(m_n - 2) % 32] : 16'h0;
                hits = 0; code = 0;
                for (int r = 0; r < 4; r++) begin
                    if (m[r*4+c]) begin hits++; code = r*4 + c; end
                end
                if (c == 0) begin
                    m_acc_hits = hits; m_acc_code = code;
                end else begin
                    if (hits > 0) m_acc_code = code;
                    m_acc_hits += hits;
                end
                if (c == 3) begin
                    kind  = (m_acc_hits == 0) ? 0 : (m_acc_hits == 1) ? 1 : 2;
                    rcode = (kind == 1) ? m_acc_code : 0;
                    if (kind == m_prev_kind && rcode == m_prev_code) begin
                        accept = (m_stable == DEB - 1);
                        if (m_stable < DEB) m_stable++;
                    end else begin
                        m_stable = 1;
                        accept = (DEB == 1);
                    end
                    m_prev_kind = kind; m_prev_code = rcode;
                    if (accept) begin
                        if (!m_pressed && kind == 1) begin
                            m_pressed = 1'b1; exp_valid = 1'b1; exp_code = rcode;
                            m_pulses++;
                        end else if (m_pressed && kind == 0) begin
                            m_pressed = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    // ---------------- stepping ----------------
    int pulses;

    task automatic step();
        logic [3:0] col_exp;
        @(posedge clk);
        model_edge();
        #1;
        col_exp = ~(4'b0001 << ((m_n / SD) % 4));
        check("col_n", bus.col_n, col_exp);
        check("key_valid", bus.key_valid, exp_valid);
        check("key_code", bus.key_code, exp_code);
        check("key_down", bus.key_down, m_pressed);
        if (bus.key_valid) pulses++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        keys = 16'h0;
        reset = 1'b1;
        m_pulses = 0;
        pulses = 0;
        run(3);
        check("reset_col_n", bus.col_n, 4'b1110);
        check("reset_key_down", bus.key_down, 1'b0);
        reset = 1'b0;

        // idle scan
        pulses = 0;
        run(100);
        check("idle_pulses", pulses, 0);

        // single key (1,2) -> code 6
        keys = 16'h1 << 6;
        pulses = 0;
        run(60);
        check("hold6_pulses", pulses, 1);
        check("hold6_code", bus.key_code, 6);
        check("hold6_down", bus.key_down, 1'b1);
        keys = 16'h0;
        pulses = 0;
        run(60);
        check("rel6_pulses", pulses, 0);
        check("rel6_down", bus.key_down, 1'b0);
        check("rel6_code", bus.key_code, 6);

        // bouncing key (3,3) then steady hold
        pulses = 0;
        m_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            keys = (i % 2 == 0) ? (16'h1 << 15) : 16'h0;
            run(5);
        end
        keys = 16'h1 << 15;
        run(60);
        check("bounce_pulses", pulses, m_pulses);
        check("bounce_code", bus.key_code, 15);
        keys = 16'h0;
        run(60);

        // two keys in different columns -> multi, no press
        keys = (16'h1 << 0) | (16'h1 << 9);
        pulses = 0;
        run(60);
        check("multi_pulses", pulses, 0);
        check("multi_down", bus.key_down, 1'b0);
        keys = 16'h1 << 0;
        run(60);
        check("multi_rel_pulses", pulses, 1);
        check("multi_rel_code", bus.key_code, 0);
        keys = 16'h0;
        run(60);

        // key change without release is ignored
        keys = 16'h1 << 1;
        pulses = 0;
        run(60);
        check("k1_pulses", pulses, 1);
        check("k1_code", bus.key_code, 1);
        keys = (16'h1 << 1) | (16'h1 << 5);
        pulses = 0;
        run(40);
        keys = 16'h1 << 5;
        run(60);
        check("swap_pulses", pulses, 0);
        check("swap_down", bus.key_down, 1'b1);
        check("swap_code", bus.key_code, 1);
        keys = 16'h0;
        run(60);
        check("swap_rel_down", bus.key_down, 1'b0);
        keys = 16'h1 << 5;
        pulses = 0;
        run(60);
        check("k5_pulses", pulses, 1);
        check("k5_code", bus.key_code, 5);
        keys = 16'h0;
        run(60);

        // reset while (2,2) is held and accepted
        keys = 16'h1 << 10;
        pulses = 0;
        run(60);
        check("k10_pulses", pulses, 1);
        check("k10_down", bus.key_down, 1'b1);
        reset = 1'b1;
        step();
        check("rst_col_n", bus.col_n, 4'b1110);
        check("rst_valid", bus.key_valid, 1'b0);
        check("rst_code", bus.key_code, 4'd0);
        check("rst_down", bus.key_down, 1'b0);
        reset = 1'b0;
        pulses = 0;
        run(51);
        check("redetect_pulses", pulses, 1);
        check("redetect_code", bus.key_code, 10);
        keys = 16'h0;
        run(60);

        // random key patterns and hold times
        for (int i = 0; i < 40; i++) begin
            int nk;
            logic [15:0] mask;
            nk = $urandom_range(0, 2);
            mask = 16'h0;
            for (int k = 0; k < nk; k++) mask = mask | (16'h1 << $urandom_range(0, 15));
            keys = mask;
            run($urandom_range(4, 50));
        end
        keys = 16'h0;
        run(60);
        check("final_down", bus.key_down, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
